rle_encoder: RTL

RLE_ENCODER -- requirements
Module: rle_encoder

---
 rtl/rle_encoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rle_encoder.sv
// ---------------------------------------------------------------------------
// rle_encoder
//
// Run-length encoder feeding a downstream byte FIFO. Consecutive equal input
// bytes are collapsed into one run, which is written to the FIFO as two bytes:
// the run length (1..MAX_RUN) followed by the symbol. A run is written out
// when the symbol changes, when it would grow past MAX_RUN, or when a byte
// flagged with in_last arrives. The byte that ends a run is parked in a
// one-entry pending slot and becomes the start of the next run once the
// current run has been written.
//
// Parameters
//   MAX_RUN    longest run carried by one count byte (2..255)
//
// Ports
//   wclk       clock, all state updates on its rising edge
//   rst        synchronous active-high reset
//   in_valid   an input byte is offered
//   in_data    offered input byte
//   in_last    offered byte ends the stream and forces a flush
//   in_ready   encoder accepts the offered byte this cycle
//   fifo_full  downstream FIFO cannot take a byte this cycle
//   wr         FIFO write strobe (combinational, never high with fifo_full)
//   data_out   byte written to the FIFO when wr=1, 8'h00 otherwise
//   busy       a run is held or being emitted
// ---------------------------------------------------------------------------
module rle_encoder #(
    parameter int unsigned MAX_RUN = 255
) (
    input  logic       wclk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       fifo_full,
    output logic       wr,
    output logic [7:0] data_out,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        EMIT_CNT = 2'd2,
        EMIT_SYM = 2'd3
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

    state_t     state;
    state_t     state_nxt;

    logic [7:0] cnt;        // length of the run being held
    logic [7:0] cur_sym;    // symbol of the run being held
    logic [7:0] pend_sym;   // byte that terminated the current run
    logic       pend;       // pend_sym holds a byte still to be encoded
    logic       pend_last;  // the pending byte carried in_last

    logic       accept;
    logic       extend;

    assign accept = in_valid & in_ready;

    // Incoming byte can be folded into the held run.
    assign extend = (in_data == cur_sym) && (cnt < MAX_CNT);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt is given a default before the case so that every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? EMIT_CNT : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // A terminating byte always flushes; a matching byte only
                    // flushes when it also ends the stream.
                    if (extend) begin
                        state_nxt = in_last ? EMIT_CNT : ACCUM;
                    end else begin
                        state_nxt = EMIT_CNT;
                    end
                end
            end
            EMIT_CNT: begin
                if (wr) begin
                    state_nxt = EMIT_SYM;
                end
            end
            EMIT_SYM: begin
                if (wr) begin
                    if (pend) begin
                        state_nxt = pend_last ? EMIT_CNT : ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. Everything is forced quiet while rst is high so a held
    // run never leaks a write during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        wr       = 1'b0;
        data_out = 8'h00;
        busy     = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            unique case (state)
                IDLE, ACCUM: begin
                    in_ready = 1'b1;
                end
                EMIT_CNT: begin
                    wr       = ~fifo_full;
                    data_out = cnt;
                end
                EMIT_SYM: begin
                    wr       = ~fifo_full;
                    data_out = cur_sym;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Run datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk) begin
        if (rst) begin
            cnt       <= 8'd0;
            cur_sym   <= 8'd0;
            pend_sym  <= 8'd0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cur_sym <= in_data;
                        cnt     <= 8'd1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (extend) begin
                            cnt <= cnt + 8'd1;
                        end else begin
                            // cnt is left alone: it is the count still to be
                            // written for the run being closed.
                            pend_sym  <= in_data;
                            pend      <= 1'b1;
                            pend_last <= in_last;
                        end
                    end
                end
                EMIT_SYM: begin
                    if (wr && pend) begin
                        cur_sym <= pend_sym;
                        cnt     <= 8'd1;
                        pend    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
